// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative divider (and the default datapath
// width also used by the MUL unit).
package div_pkg;

    localparam int DIV_WIDTH_DEFAULT = 32;
    localparam int MAX_W             = 64;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    // Two's-complement negate when neg=1; callers cast the result back to their width.
    function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] v, input logic neg);
        return neg ? (~v + MAX_W'(1)) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: shift in a dividend bit, trial-subtract
// the divisor magnitude, keep the difference if it did not go negative.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic [WIDTH:0]   prem,
    input  logic             dbit,
    input  logic [WIDTH-1:0] dsr,
    output logic [WIDTH:0]   prem_nx,
    output logic             qbit
);

    // One extra bit above the partial remainder so the trial difference's sign is exact.
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    always_comb begin
        shifted = {prem, dbit};
        diff    = shifted - {2'b00, dsr};
        qbit    = ~diff[WIDTH+1];
        prem_nx = qbit ? diff[WIDTH:0] : shifted[WIDTH:0];
    end

endmodule

// File: rtl/div_iter_param.sv
// Multi-cycle signed/unsigned integer divider, one quotient bit per clock.
// Optional DIV_ZERO_CHK_EN: zero divisor skips the iterations and raises dz.
module div_iter_param
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             dz
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH:0]     prem;
    logic [WIDTH-1:0]   dvd;      // dividend magnitude, shifted out as quotient bits shift in
    logic [WIDTH-1:0]   dsr;
    logic               sign_q;
    logic               sign_r;
    logic               zdiv;
    logic               skip_calc;
    logic [WIDTH:0]     step_rem;
    logic               step_q;
    logic [WIDTH-1:0]   rem_mag;

`ifdef DIV_ZERO_CHK_EN
    logic dz_q;
    assign skip_calc = zdiv;
    assign dz        = dz_q;
`else
    assign skip_calc = 1'b0;
    assign dz        = 1'b0;
`endif

    assign busy    = (state != IDLE);
    assign rem_mag = skip_calc ? dvd : prem[WIDTH-1:0];

    div_step #(.WIDTH(WIDTH)) u_step (
        .prem    (prem),
        .dbit    (dvd[WIDTH-1]),
        .dsr     (dsr),
        .prem_nx (step_rem),
        .qbit    (step_q)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // NOTE: next-state gets a default before the case so no latch is inferred.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = CALC;
            CALC:    if (skip_calc || cnt == CNT_W'(1)) state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            prem   <= '0;
            dvd    <= '0;
            dsr    <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            zdiv   <= 1'b0;
            q      <= '0;
            r      <= '0;
            done   <= 1'b0;
`ifdef DIV_ZERO_CHK_EN
            dz_q   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: if (start) begin
                    dvd    <= WIDTH'(cond_neg(MAX_W'(dividend), is_signed & dividend[WIDTH-1]));
                    dsr    <= WIDTH'(cond_neg(MAX_W'(divisor),  is_signed & divisor[WIDTH-1]));
                    sign_q <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    sign_r <= is_signed & dividend[WIDTH-1];
                    zdiv   <= (divisor == '0);
                    prem   <= '0;
                    cnt    <= CNT_W'(WIDTH);
                end
                CALC: if (!skip_calc) begin
                    prem <= step_rem;
                    dvd  <= {dvd[WIDTH-2:0], step_q};
                    cnt  <= cnt - CNT_W'(1);
                end
                FIX: begin
                    // Zero divisor: all-ones quotient; remainder magnitude re-signed gives the raw dividend.
                    q    <= zdiv ? '1 : WIDTH'(cond_neg(MAX_W'(dvd), sign_q));
                    r    <= WIDTH'(cond_neg(MAX_W'(rem_mag), sign_r));
                    done <= 1'b1;
`ifdef DIV_ZERO_CHK_EN
                    dz_q <= zdiv;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter_param.sv
// Randomized self-checking bench for div_iter_param (WIDTH=32 and WIDTH=8 instances),
// compared against an arithmetic reference model.
module tb_div_iter_param;

`ifdef DIV_ZERO_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;

    logic        start32, sgn32, busy32, done32, dz32;
    logic [31:0] dvd32, dsr32, q32, r32;
    logic        start8, sgn8, busy8, done8, dz8;
    logic [7:0]  dvd8, dsr8, q8, r8;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    div_iter_param #(.WIDTH(32)) dut32 (
        .clock(clock), .reset(reset), .start(start32), .is_signed(sgn32),
        .dividend(dvd32), .divisor(dsr32), .q(q32), .r(r32),
        .busy(busy32), .done(done32), .dz(dz32)
    );

    div_iter_param #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset), .start(start8), .is_signed(sgn8),
        .dividend(dvd8), .divisor(dsr8), .q(q8), .r(r8),
        .busy(busy8), .done(done8), .dz(dz8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] wmask(input int w);
        return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    // Reference: truncating division on sign-extended 64-bit integers.
    function automatic void model(input int w, input bit sgn, input logic [63:0] a_in,
                                  input logic [63:0] b_in, output logic [63:0] eq,
                                  output logic [63:0] er);
        logic [63:0] m, a, b;
        longint sa, sb;
        m = wmask(w);
        a = a_in & m;
        b = b_in & m;
        if (b == 0) begin
            eq = m;
            er = a;
        end else if (sgn) begin
            sa = a[w-1] ? longint'(a | ~m) : longint'(a);
            sb = b[w-1] ? longint'(b | ~m) : longint'(b);
            eq = 64'(sa / sb) & m;
            er = 64'(sa % sb) & m;
        end else begin
            eq = (a / b) & m;
            er = (a % b) & m;
        end
    endfunction

    task automatic drive(input int w, input bit st, input bit sgn, input logic [63:0] a,
                         input logic [63:0] b);
        if (w == 32) begin
            start32 = st; sgn32 = sgn; dvd32 = a[31:0]; dsr32 = b[31:0];
        end else begin
            start8 = st; sgn8 = sgn; dvd8 = a[7:0]; dsr8 = b[7:0];
        end
    endtask

    function automatic logic [63:0] rd_q(input int w);
        return (w == 32) ? 64'(q32) : 64'(q8);
    endfunction
    function automatic logic [63:0] rd_r(input int w);
        return (w == 32) ? 64'(r32) : 64'(r8);
    endfunction
    function automatic logic rd_busy(input int w);
        return (w == 32) ? busy32 : busy8;
    endfunction
    function automatic logic rd_done(input int w);
        return (w == 32) ? done32 : done8;
    endfunction
    function automatic logic rd_dz(input int w);
        return (w == 32) ? dz32 : dz8;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // One operation: optional start pulse during the run (inject_at), optional
    // chaining of the next start into the done cycle.
    task automatic do_op(input int w, input bit sgn, input logic [63:0] a, input logic [63:0] b,
                         input int inject_at, input bit pre_started, input bit chain,
                         input bit nsgn, input logic [63:0] na, input logic [63:0] nb,
                         input string tag);
        logic [63:0] eq, er;
        int n, exp_lat;
        bit seen, zero_b;
        model(w, sgn, a, b, eq, er);
        zero_b  = ((b & wmask(w)) == 0);
        exp_lat = (CHK && zero_b) ? 2 : w + 1;
        if (!pre_started) begin
            @(negedge clock);
            drive(w, 1'b1, sgn, a, b);
        end
        @(posedge clock);
        #1;
        drive(w, 1'b0, $urandom_range(0, 1) == 1, rnd64(), rnd64());
        check({tag, ":busy_start"}, 64'(rd_busy(w)), 64'd1);
        if (pre_started) check({tag, ":done_drop"}, 64'(rd_done(w)), 64'd0);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 3 * w + 10) begin
            @(posedge clock);
            n++;
            #1;
            if (rd_done(w)) seen = 1'b1;
            else if (n == inject_at) drive(w, 1'b1, ~sgn, rnd64(), rnd64() | 64'd1);
            else drive(w, 1'b0, $urandom_range(0, 1) == 1, rnd64(), rnd64());
        end
        check({tag, ":latency"}, 64'(n), 64'(exp_lat));
        check({tag, ":q"}, rd_q(w), eq);
        check({tag, ":r"}, rd_r(w), er);
        check({tag, ":dz"}, 64'(rd_dz(w)), 64'(CHK && zero_b));
        check({tag, ":busy_done"}, 64'(rd_busy(w)), 64'd0);
        if (chain) begin
            drive(w, 1'b1, nsgn, na, nb);
        end else begin
            @(posedge clock);
            #1;
            check({tag, ":done_pulse"}, 64'(rd_done(w)), 64'd0);
        end
    endtask

    task automatic op(input int w, input bit sgn, input logic [63:0] a, input logic [63:0] b,
                      input string tag);
        do_op(w, sgn, a, b, -1, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a, b;
        bit sgn;
        reset = 1'b0;
        drive(32, 1'b0, 1'b0, 64'd0, 64'd0);
        drive(8, 1'b0, 1'b0, 64'd0, 64'd0);
        #2;
        check("rst:q32", 64'(q32), 64'd0);
        check("rst:r32", 64'(r32), 64'd0);
        check("rst:busy32", 64'(busy32), 64'd0);
        check("rst:done32", 64'(done32), 64'd0);
        check("rst:dz32", 64'(dz32), 64'd0);
        check("rst:busy8", 64'(busy8), 64'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;

        // Directed vectors, WIDTH=32.
        op(32, 1'b1, 64'd20, 64'd3, "s20/3");
        op(32, 1'b1, 64'hFFFFFFEC, 64'd3, "s-20/3");
        op(32, 1'b1, 64'd20, 64'hFFFFFFFD, "s20/-3");
        op(32, 1'b1, 64'hFFFFFFEC, 64'hFFFFFFFD, "s-20/-3");
        op(32, 1'b1, 64'h7FFFFFFF, 64'd2, "smax/2");
        op(32, 1'b0, 64'hFFFFFFEC, 64'd3, "u_big/3");
        op(32, 1'b1, 64'h80000000, 64'hFFFFFFFF, "smin/-1");
        op(32, 1'b1, 64'h14, 64'd0, "s_div0");
        op(32, 1'b0, 64'h14, 64'd0, "u_div0");
        op(32, 1'b1, 64'hFFFFFFEC, 64'd0, "s_neg_div0");
        op(32, 1'b0, 64'd5, 64'd7, "u_small");

        // Start pulse while busy must be ignored.
        do_op(32, 1'b1, 64'hFFFFF000, 64'd13, 5, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, "inject");

        // Reset in the middle of an operation.
        @(negedge clock);
        drive(32, 1'b1, 1'b1, 64'd1000, 64'd7);
        @(posedge clock);
        #1;
        drive(32, 1'b0, 1'b0, 64'd0, 64'd0);
        repeat (10) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("midrst:busy", 64'(busy32), 64'd0);
        check("midrst:q", 64'(q32), 64'd0);
        check("midrst:r", 64'(r32), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            check("midrst:no_done", 64'(done32), 64'd0);
        end
        @(negedge clock);
        reset = 1'b1;
        op(32, 1'b1, 64'd1000, 64'hFFFFFFF9, "after_rst");

        // WIDTH=8 with back-to-back start in the done cycle.
        do_op(8, 1'b1, 64'h81, 64'h07, -1, 1'b0, 1'b1, 1'b1, 64'h64, 64'hF9, "w8_a");
        do_op(8, 1'b1, 64'h64, 64'hF9, -1, 1'b1, 1'b1, 1'b0, 64'hC8, 64'h0B, "w8_b");
        do_op(8, 1'b0, 64'hC8, 64'h0B, -1, 1'b1, 1'b0, 1'b0, 64'd0, 64'd0, "w8_c");
        op(8, 1'b1, 64'h80, 64'hFF, "w8_min/-1");
        op(8, 1'b1, 64'h85, 64'h00, "w8_div0");

        // Randomized operations.
        for (int i = 0; i < 30; i++) begin
            sgn = $urandom_range(0, 1) == 1;
            a = rnd64();
            case ($urandom_range(0, 7))
                0:       b = 64'd0;
                1:       b = 64'd1;
                2:       b = '1;
                3, 4:    b = 64'($urandom_range(1, 15));
                default: b = rnd64();
            endcase
            op(32, sgn, a, b, "rnd32");
        end
        for (int i = 0; i < 30; i++) begin
            sgn = $urandom_range(0, 1) == 1;
            a = rnd64();
            b = ($urandom_range(0, 9) == 0) ? 64'd0 : rnd64();
            op(8, sgn, a, b, "rnd8");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
